sr_latch_ctrl: RTL and testbench

Synchronous request sequencer for a NOR SR latch (`sr_latch_nor`). It arbitrates set/reset requests from `NREQ` requesters and drives the latch's `s`/`r` inputs with fixed-width pulses separated by guard gaps, so the forbidden `s=r=1` input can never occur. After each operation it reads back `q`/`qbar` and reports completion and error per request. It sits between clocked control logic and the asynchronous latch.

---
 rtl/sr_latch_ctrl_pkg.sv | 25 ++
 rtl/sr_latch_ctrl_if.sv | 38 +++
 rtl/sr_latch_ctrl_arbiter.sv | 55 +++++
 rtl/sr_latch_ctrl.sv | 146 ++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and constants for the SR latch pulse sequencer.
// State/op encodings plus width helpers.
package sr_latch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int p, input int g);
    int m;
    m = (p > g) ? p : g;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// Requester-side handshake and completion bundle
// of the SR latch sequencer.
interface sr_latch_ctrl_if
  import sr_latch_ctrl_pkg::*;
#(
  parameter int NREQ = 2
);
  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_op;
  logic [NREQ-1:0] req_ready;
  logic            busy;
  logic            done;
  logic [IW-1:0]   done_id;
  logic            err;

  modport master (
    output req_valid,
    output req_op,
    input  req_ready,
    input  busy,
    input  done,
    input  done_id,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    output req_ready,
    output busy,
    output done,
    output done_id,
    output err
  );

endinterface

// File: rtl/sr_latch_ctrl_arbiter.sv
// Round-robin arbiter: combinational one-hot grant,
// pointer moves past the winner when en is high.
module rr_arbiter
  import sr_latch_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] gidx;
  logic [IW-1:0] jw;
  logic          found;
  int            j;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    jw    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      jw = IW'(j);
      if (!found && req[jw]) begin
        found     = 1'b1;
        gidx      = jw;
        grant[jw] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && found) begin
      if (gidx == IW'(N - 1)) ptr_d = '0;
      else                    ptr_d = gidx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer driving NOR SR latch set/reset pulses with
// guard gaps, then checking q/qbar readback.
module sr_latch_ctrl
  import sr_latch_ctrl_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sr_latch_ctrl_if.slave bus,
  output logic          s,
  output logic          r,
  input  logic          q,
  input  logic          qbar
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = cnt_w(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] P_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_q, op_d;
  logic [IW-1:0]   id_q, id_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            done_q, done_d;
  logic [IW-1:0]   done_id_q, done_id_d;

  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_op;
  logic            idle;
  logic            xfer;
  logic            rb_ok;

  assign idle    = (state_q == ST_IDLE);
  assign arb_req = bus.req_valid & {NREQ{idle & rst_n}};

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .en    (idle),
    .grant (grant)
  );

  assign xfer     = |grant;
  assign grant_op = |(grant & bus.req_op);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end

  // s/r are registered from state so they are glitch-free at the latch
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    id_d      = id_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    done_d    = 1'b0;
    done_id_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_DRIVE;
          cnt_d   = P_LD;
          op_d    = grant_op;
          id_d    = grant_idx;
          s_d     = grant_op;
          r_d     = ~grant_op;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = G_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
          s_d   = op_q;
          r_d   = ~op_q;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d   = ST_CHECK;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_RESET;
      id_q      <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      id_q      <= id_d;
      s_q       <= s_d;
      r_q       <= r_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  // both-0 or both-1 on q/qbar fails either compare
  assign rb_ok = (q == op_q) & (qbar == ~op_q);

  assign s             = s_q;
  assign r             = r_q;
  assign bus.req_ready = grant;
  assign bus.busy      = ~idle;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.err       = done_q & ~rb_ok;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench: directed and random requests
// against a cycle-offset reference schedule.
module tb_sr_latch_ctrl;

  localparam int N = 2;
  localparam int P = 4;
  localparam int G = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic s, r, q, qbar;
  logic lat   = 1'b0;
  logic fault = 1'b0;

  sr_latch_ctrl_if #(.NREQ(N)) bus ();

  sr_latch_ctrl #(
    .NREQ         (N),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .s     (s),
    .r     (r),
    .q     (q),
    .qbar  (qbar)
  );

  always #5 clk = ~clk;

  // behavioural NOR latch, optionally stuck at q=0/qbar=1
  always @(posedge clk) begin
    if (s && !r)      lat <= 1'b1;
    else if (r && !s) lat <= 1'b0;
  end
  assign q    = fault ? 1'b0 : lat;
  assign qbar = fault ? 1'b1 : ~lat;

  int       n_chk  = 0;
  int       n_fail = 0;
  int       cyc    = 0;
  int       gcyc   = 0;
  int       gid    = 0;
  int       ptr_m  = 0;
  int       zrun   = 0;
  bit       active = 0;
  bit       gop    = 0;
  bit       lat_m  = 0;
  bit       rnd_en = 0;
  bit       seen   = 0;
  bit       last_s = 0;
  bit       prev_done = 0;
  bit [N-1:0] vld = '0;
  bit [N-1:0] ops = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit rst_lvl);
    int         k;
    int         widx;
    bit         found;
    bit [N-1:0] e_rdy;
    bit         e_s, e_r, e_busy, e_done, e_err;
    bit         rb_q, rb_qb;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = rst_lvl;
    if (rnd_en) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) begin
          vld[i] = 1'b1;
          ops[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    bus.req_valid = vld;
    bus.req_op    = ops;
    @(negedge clk);
    k      = cyc - gcyc;
    e_rdy  = '0;
    e_s    = 0;
    e_r    = 0;
    e_busy = 0;
    e_done = 0;
    widx   = 0;
    found  = 0;
    if (active) begin
      e_busy = 1;
      if (k >= 1 && k <= P) begin
        e_s = gop;
        e_r = !gop;
      end
      e_done = (k == P + G + 1);
    end else if (rst_n) begin
      for (int j = 0; j < N; j++) begin
        if (!found && vld[(ptr_m + j) % N]) begin
          found       = 1;
          widx        = (ptr_m + j) % N;
          e_rdy[widx] = 1'b1;
        end
      end
    end
    check("req_ready", bus.req_ready, e_rdy);
    check("s", s, e_s);
    check("r", r, e_r);
    check("busy", bus.busy, e_busy);
    check("done", bus.done, e_done);
    if (e_done) begin
      rb_q  = fault ? 1'b0 : lat_m;
      rb_qb = fault ? 1'b1 : !lat_m;
      e_err = !(rb_q == gop && rb_qb == !gop);
      check("done_id", bus.done_id, gid);
      check("err", bus.err, e_err);
      if (!fault) check("q", q, gop);
    end
    check("s_and_r", s & r, 0);
    check("rdy_onehot0", $onehot0(bus.req_ready), 1);
    check("done_width", prev_done & bus.done, 0);
    if (s | r) begin
      if (seen && (zrun > 0 || s != last_s))
        check("gap_len", zrun >= G, 1);
      seen   = 1;
      last_s = s;
      zrun   = 0;
    end else begin
      zrun++;
    end
    prev_done = bus.done;
    if (e_s)      lat_m = 1;
    else if (e_r) lat_m = 0;
    if (active && k == P + G + 1) active = 0;
    if (found) begin
      active    = 1;
      gcyc      = cyc;
      gid       = widx;
      gop       = ops[widx];
      ptr_m     = (widx + 1) % N;
      vld[widx] = 1'b0;
    end
    if (!rst_n) begin
      active = 0;
      ptr_m  = 0;
      seen   = 0;
      zrun   = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    // reset with both requesters already asserting
    vld = 2'b11;
    ops = 2'b01;
    repeat (3) step(0);
    check("rst_done_id", bus.done_id, 0);
    check("rst_err", bus.err, 0);
    // contention: grant 0 (set), then 1 (reset)
    run(2 * (P + G + 2) + 2);
    check("rr_q_after", q, 0);
    // simultaneous again: pointer wrapped to 0
    vld = 2'b11;
    ops = 2'b10;
    run(2 * (P + G + 2) + 2);
    // single set
    vld = 2'b01;
    ops = 2'b01;
    run(P + G + 4);
    check("single_q", q, 1);
    // readback fault: set errors, reset reads back fine
    fault = 1'b1;
    vld = 2'b01;
    ops = 2'b01;
    run(P + G + 4);
    vld = 2'b10;
    ops = 2'b00;
    run(P + G + 4);
    fault = 1'b0;
    // reset mid-DRIVE
    vld = 2'b10;
    ops = 2'b10;
    for (int t = 0; t < 20 && !active; t++) step(1);
    check("grant_seen", active, 1);
    step(1);
    step(0);
    vld = 2'b11;
    ops = 2'b01;
    run(2 * (P + G + 2) + 2);
    // random traffic, occasional resets and faults
    rnd_en = 1;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) fault = 1'b1;
      if (i == 450) fault = 1'b0;
      step($urandom_range(0, 59) != 0);
    end
    rnd_en = 0;
    run(2 * (P + G + 2) + 4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
